input_pad_loader: RTL and testbench
===================================

# input_pad_loader

Front-end load stage of the CNN accelerator. It accepts the 16x16 signed 16-bit input image as a raster stream and writes it, with a one-pixel zero border, into the 18x18 first input memory. That memory is single-port, synchronous write, with word address = row*18 + col. The block owns the memory's address, data and write-enable during a load and signals completion to the layer-1 convolution control.

## Interface
Parameters:
- IMG, 16: image side length in pixels
- PAD, 1: border width in pixels; padded side is IMG+2*PAD = 18
- DW, 16: pixel width, two's complement
- AW, 16: memory address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-high (1 = reset) despite the suffix
- start  in  1  begin a frame load; sampled only in IDLE
- in_valid  in  1  in_data holds a valid pixel
- in_data  in  DW  signed pixel, raster order (row-major, row 0 first)
- in_ready  out  1  block accepts in_data this cycle
- mem_addr  out  AW  write address to input memory
- mem_din  out  DW  write data
- mem_we  out  1  write enable
- busy  out  1  load in progress
- done  out  1  single-cycle pulse, frame fully written

## Operation
- States: IDLE, FILL, DONE.
- IDLE -> FILL when start=1. Position counters row=0 and col=0 are loaded on that transition. start is ignored in FILL and DONE.
- FILL walks every padded position (row 0..17, col 0..17) in raster order, one position per advance.
- A position is interior when PAD <= row <= PAD+IMG-1 and PAD <= col <= PAD+IMG-1. All other positions are border.
- Border position:
  - always advances in one cycle;
  - writes 0;
  - does not consume input;
  - in_ready=0.
- Interior position:
  - in_ready=1;
  - advances and writes in_data only on cycles with in_valid=1;
  - otherwise holds the position and issues no write (stall; mem_we=0 next cycle).
- Advance: col increments. At col=17 it wraps to 0 and row increments. The advance out of (17,17) goes to DONE.
- DONE: lasts one cycle, done=1, then returns to IDLE.
- in_ready is combinational: (state==FILL) && interior. It never depends on in_valid.
- A pixel transfer occurs only when in_valid && in_ready. Data offered while in_ready=0 is not consumed.
- Address arithmetic: mem_addr = row*18 + col, computed at AW bits, maximum 323. A running address counter is acceptable.
- Data passes unmodified; no saturation and no sign changes.
- Exactly 324 writes per frame: 68 border zeros and 256 pixels.
- Reset (any state, including mid-frame):
  - returns to IDLE and clears the counters;
  - all outputs are 0 on the cycle after rst_n is sampled high;
  - memory contents from a partial frame are undefined;
  - a new start restarts at address 0.
- start and rst_n both high: reset wins.

## Timing
- Outputs mem_addr, mem_din, mem_we, busy and done are registered.
- Reset values: all outputs 0, including in_ready (state IDLE).
- start sampled at edge E0:
  - FILL begins in cycle 1 after E0;
  - the write for position (0,0) is presented in cycle 2.
- Write for the position decided in cycle k is presented (mem_we=1) in cycle k+1.
- With in_valid held high:
  - writes are presented in cycles 2..325, one per cycle;
  - done=1 in cycle 326;
  - busy=1 in cycles 1..325;
  - busy=0 in cycle 326 (same cycle as done).
- Each stalled interior cycle delays all subsequent writes and done by one cycle.
- Back-to-back frames: start may be asserted in the done cycle. It is sampled in IDLE on the following edge.

## Test plan
- Reset: hold rst_n=1 for 2 cycles with start=1 and in_valid=1 → all outputs 0 and no write issued.
- Full frame, in_valid constant 1, in_data = transfer index 0..255, with the stimulus in_data tracking the transfer count (not the cycle count, since border cycles consume nothing) → 324 writes on consecutive cycles 2..325:
  - addr 0..18 get 0;
  - addr 19 gets 0;
  - addr 34 gets 15;
  - addr 37 gets 16;
  - addr 304 gets 255;
  - addr 305..323 get 0;
  - done in cycle 326.
- in_valid pattern 1,0,0,1 repeating → every pixel written exactly once in order. Border zeros continue without valid, and no write occurs on stalled cycles. Final memory image matches the previous test.
- start pulsed again at write 50 → ignored; exactly 324 writes and a single done.
- rst_n=1 at write 100 → next cycle all outputs 0. A fresh start then produces the first write at addr 0 and a complete 324-write frame.
- Pixels -32768, -1, 32767 at interior positions → written to their mapped addresses (e.g. the first three transfers land at addr 19, 20, 21) bit-exact.

Source files
------------

// File: rtl/input_pad_loader_if.sv
// Handshake and memory-write bundle between the pixel source, the pad loader
// and the layer-1 input memory / convolution control.
interface input_pad_loader_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic          busy;
  logic          done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_addr, mem_din, mem_we, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_addr, mem_din, mem_we, busy, done
  );
endinterface

// File: rtl/input_pad_loader.sv
// Streams a raster IMGxIMG image into the padded input memory, writing zeros on
// the PAD-wide border and one accepted pixel per interior position.
module input_pad_loader #(
  parameter int IMG = 16,
  parameter int PAD = 1,
  parameter int DW  = 16,
  parameter int AW  = 16
) (
  input  logic               clk,
  input  logic               rst_n,  // active-high synchronous reset
  input_pad_loader_if.slave  bus
);
  localparam int SIDE = IMG + 2*PAD;
  localparam int CW   = $clog2(SIDE);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          interior, advance;

  assign interior = (row_q >= CW'(PAD)) && (row_q <= CW'(PAD+IMG-1)) &&
                    (col_q >= CW'(PAD)) && (col_q <= CW'(PAD+IMG-1));
  // Border positions never wait; interior ones wait for a pixel.
  assign advance  = !interior || bus.in_valid;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = '0;
    mem_we_d   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = FILL;
        row_d   = '0;
        col_d   = '0;
        addr_d  = '0;
      end
      FILL: if (advance) begin
        mem_we_d   = 1'b1;
        mem_addr_d = addr_q;
        mem_din_d  = interior ? bus.in_data : '0;
        addr_d     = addr_q + AW'(1);
        if (col_q == CW'(SIDE-1)) begin
          col_d = '0;
          if (row_q == CW'(SIDE-1)) state_d = DONE;
          else                      row_d   = row_q + CW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // busy covers the DONE state so it drops in the same cycle done rises.
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready = (state_q == FILL) && interior;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_input_pad_loader.sv
// Scoreboarded bench for input_pad_loader: the stimulus side queues the expected
// write sequence per frame, a negedge monitor pops and compares every write.
module tb_input_pad_loader;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NPOS = 324;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  input_pad_loader_if #(.DW(DW), .AW(AW)) pif ();
  input_pad_loader #(.IMG(16), .PAD(1), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(pif.slave)
  );

  int npass = 0, ntot = 0;
  int cyc = 0, f0 = 0;
  bit in_frame = 0;
  wr_t exp_q[$];
  logic [DW-1:0] pix [256];
  logic [DW-1:0] img [NPOS];
  logic [DW-1:0] img_a [NPOS];
  int wcount, dcount, first_k, last_k, done_k;
  logic busy1, busy325, busy326;
  bit stalled_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int k;
    wr_t w;
    k = cyc - f0 + 1;
    if (stalled_prev) chk("no_write_after_stall", {31'd0, pif.mem_we}, 32'd0);
    stalled_prev = in_frame && pif.in_ready && !pif.in_valid;
    if (pif.mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {16'd0, pif.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("write", {pif.mem_addr, pif.mem_din}, {w.addr, w.data});
      end
      if (pif.mem_addr < NPOS) img[pif.mem_addr] = pif.mem_din;
      wcount++;
      if (first_k < 0) first_k = k;
      last_k = k;
    end
    if (pif.done) begin
      dcount++;
      done_k = k;
    end
    if (in_frame) begin
      if (k == 1)   busy1   = pif.busy;
      if (k == 325) busy325 = pif.busy;
      if (k == 326) busy326 = pif.busy;
    end
  end

  task automatic check_idle(input string nm);
    chk({nm, "_we"},    {31'd0, pif.mem_we},   32'd0);
    chk({nm, "_busy"},  {31'd0, pif.busy},     32'd0);
    chk({nm, "_done"},  {31'd0, pif.done},     32'd0);
    chk({nm, "_rdy"},   {31'd0, pif.in_ready}, 32'd0);
    chk({nm, "_addr"},  {16'd0, pif.mem_addr}, 32'd0);
    chk({nm, "_din"},   {16'd0, pif.mem_din},  32'd0);
  endtask

  // vpat 0: in_valid always 1; vpat 1: 1,0,0,1 repeating.
  task automatic run_frame(input int vpat, input int restart_at, input int reset_at);
    int xfer, r, c, p;
    bit restarted;
    wr_t w;
    p = 0;
    for (int a = 0; a < NPOS; a++) begin
      r = a / 18; c = a % 18;
      w.addr = AW'(a);
      if (r >= 1 && r <= 16 && c >= 1 && c <= 16) begin w.data = pix[p]; p++; end
      else w.data = '0;
      exp_q.push_back(w);
      img[a] = 16'hDEAD;
    end
    wcount = 0; dcount = 0; first_k = -1; last_k = -1; done_k = -1;
    busy1 = 1'bx; busy325 = 1'bx; busy326 = 1'bx;
    xfer = 0; restarted = 0;
    pif.start = 1'b1;
    @(posedge clk); #1;
    pif.start = 1'b0;
    f0 = cyc;
    in_frame = 1;
    for (int k = 1; k < 2000; k++) begin
      pif.in_valid = (vpat == 0) ? 1'b1 : ((k % 4 == 1) || (k % 4 == 0));
      pif.in_data  = (xfer < 256) ? pix[xfer] : '0;
      if (restart_at > 0 && !restarted && wcount >= restart_at) begin
        pif.start = 1'b1; restarted = 1;
      end else pif.start = 1'b0;
      if (reset_at > 0 && wcount >= reset_at) begin
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        pif.in_valid = 1'b0;
        exp_q.delete();
        in_frame = 0;
        check_idle("mid_reset");
        return;
      end
      if (pif.in_valid && pif.in_ready) xfer++;
      @(posedge clk); #1;
      if (dcount > 0) break;
    end
    pif.in_valid = 1'b0;
    pif.start = 1'b0;
    chk("frame_finished", {31'd0, dcount > 0}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    in_frame = 0;
    chk("write_count", wcount, NPOS);
    chk("done_count", dcount, 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("xfer_count", xfer, 256);
  endtask

  initial begin
    pif.start = 1'b1; pif.in_valid = 1'b1; pif.in_data = 16'h1234;
    rst_n = 1'b1;
    wcount = 0; dcount = 0;
    @(posedge clk); #1;
    check_idle("reset1");
    @(posedge clk); #1;
    check_idle("reset2");
    rst_n = 1'b0; pif.start = 1'b0; pif.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("reset_no_write", wcount, 0);

    // Frame A: in_valid constant, pixels = transfer index
    for (int i = 0; i < 256; i++) pix[i] = DW'(i);
    run_frame(0, 0, 0);
    chk("first_write_cycle", first_k, 2);
    chk("last_write_cycle", last_k, 325);
    chk("done_cycle", done_k, 326);
    chk("busy_c1", {31'd0, busy1}, 32'd1);
    chk("busy_c325", {31'd0, busy325}, 32'd1);
    chk("busy_c326", {31'd0, busy326}, 32'd0);
    for (int a = 0; a <= 18; a++) chk("top_border", {16'd0, img[a]}, 32'd0);
    chk("addr19", {16'd0, img[19]}, 32'd0);
    chk("addr34", {16'd0, img[34]}, 32'd15);
    chk("addr37", {16'd0, img[37]}, 32'd16);
    chk("addr304", {16'd0, img[304]}, 32'd255);
    for (int a = 305; a < NPOS; a++) chk("bottom_border", {16'd0, img[a]}, 32'd0);
    for (int a = 0; a < NPOS; a++) img_a[a] = img[a];

    // Frame B: 1,0,0,1 valid pattern, same final image
    run_frame(1, 0, 0);
    for (int a = 0; a < NPOS; a++) chk("stall_image", {16'd0, img[a]}, {16'd0, img_a[a]});

    // Frame C: start pulsed mid-frame is ignored
    run_frame(0, 50, 0);

    // Frame D: reset at write 100
    run_frame(0, 0, 100);
    @(posedge clk); #1;
    check_idle("post_reset");

    // Frame E: fresh start after reset, extreme signed pixels
    for (int i = 0; i < 256; i++) pix[i] = DW'(i * 257);
    pix[0] = 16'h8000; pix[1] = 16'hFFFF; pix[2] = 16'h7FFF;
    run_frame(0, 0, 0);
    chk("fresh_first_write", first_k, 2);
    chk("addr19_min", {16'd0, img[19]}, 32'h8000);
    chk("addr20_neg1", {16'd0, img[20]}, 32'hFFFF);
    chk("addr21_max", {16'd0, img[21]}, 32'h7FFF);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
